// File: rtl/gyro_rx_lane_packer_pkg.sv
// Shared definitions for the gyro serializer receive path.
// Contents: word/sample/beat widths, base packet length, the lane
// enumeration and small helpers for packet length and lane selection.
package gyro_serdes_pkg;

  localparam int WORD_W   = 48;
  localparam int SAMPLE_W = 16;
  localparam int PKT_BASE = 64;
  localparam int AXI_W    = 32;

  typedef enum logic [1:0] {LANE0 = 2'd0, LANE1 = 2'd1, LANE2 = 2'd2} lane_e;

  // Packet length in words: 64 << sel, so 64 up to 8192.
  function automatic logic [13:0] pkt_len(input logic [2:0] sel);
    return 14'(PKT_BASE) << sel;
  endfunction

  // Highest enabled lane of a mask (lanes are emitted high to low).
  function automatic lane_e first_lane(input logic [2:0] mask);
    lane_e lane;
    if (mask[2])      lane = LANE2;
    else if (mask[1]) lane = LANE1;
    else              lane = LANE0;
    return lane;
  endfunction

  // True when no enabled lane remains below the given one.
  function automatic logic lane_is_last(input logic [2:0] mask, input lane_e lane);
    logic last;
    case (lane)
      LANE2:   last = (mask[1:0] == 2'b00);
      LANE1:   last = ~mask[0];
      default: last = 1'b1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/gyro_rx_lane_packer_if.sv
// Stream bus of the lane packer: 48-bit word input from the RX FIFO
// (s_*) and 32-bit tagged beat output toward the DMA (m_*).
// slave  : the packer side (consumes s_*, drives m_*).
// master : the environment side (drives s_*, consumes m_*).
interface gyro_rx_lane_packer_if;
  import gyro_serdes_pkg::*;

  logic [WORD_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [AXI_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/gyro_rx_lane_packer_lane_sel.sv
// gyro_lane_sel: picks the lane to present next.
// i_start   : a new word is being loaded, so start from its highest lane.
// i_mask    : lane enable mask of the word.
// i_lane    : lane currently presented (ignored when i_start).
// o_lane    : lane to present next.
// o_is_last : o_lane is the final enabled lane of the word.
module gyro_lane_sel
  import gyro_serdes_pkg::*;
(
  input  logic       i_start,
  input  logic [2:0] i_mask,
  input  lane_e      i_lane,
  output lane_e      o_lane,
  output logic       o_is_last
);

  // Only lane 2 can step to lane 1; every other step lands on lane 0,
  // which must be enabled whenever the current lane was not the last one.
  always_comb begin
    o_lane = LANE0;
    if (i_start)
      o_lane = first_lane(i_mask);
    else if ((i_lane == LANE2) && i_mask[1])
      o_lane = LANE1;
    o_is_last = lane_is_last(i_mask, o_lane);
  end

endmodule

// File: rtl/gyro_rx_lane_packer.sv
// gyro_rx_lane_packer: splits 48-bit RX words into 16-bit lanes and emits
// each enabled lane as a tagged 32-bit beat, adding packet framing.
// clock, reset    : system clock, synchronous active-high reset.
// in_start_stop   : 1 = accept new words; the held word always drains.
// packet_sel      : packet length 64 << packet_sel words.
// in_channel      : lane enable mask (bit2 = [47:32] ... bit0 = [15:0]).
// bus (slave)     : s_* word input, m_* beat output {lane,2'b00,seq,sample}.
// packet_count    : completed packets, wrapping.
// busy            : a word is held or a packet is open.
module gyro_rx_lane_packer
  import gyro_serdes_pkg::*;
#(
  parameter int SEQ_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_start_stop,
  input  logic [2:0]            packet_sel,
  input  logic [2:0]            in_channel,
  gyro_rx_lane_packer_if.slave  bus,
  output logic [15:0]           packet_count,
  output logic                  busy
);

  logic              r_hold_valid;
  logic [WORD_W-1:0] r_hold_data;
  logic [SEQ_W-1:0]  r_hold_seq;
  lane_e             r_lane;
  logic [2:0]        r_mask;
  logic [2:0]        r_sel;
  logic [SEQ_W-1:0]  r_seq;
  logic [12:0]       r_idx;
  logic              r_word_last;
  logic [AXI_W-1:0]  r_tdata;
  logic              r_tlast;
  logic [15:0]       r_pkt_cnt;

  logic              w_cur_last;
  logic              w_fire;
  logic              w_accept_rdy;
  logic              w_accept;
  logic              w_new_pkt;
  logic [2:0]        w_word_mask;
  logic [2:0]        w_word_sel;
  logic [12:0]       w_len_m1;
  logic              w_word_last;
  logic [2:0]        w_sel_mask;
  lane_e             w_next_lane;
  logic              w_next_is_last;
  logic [WORD_W-1:0] w_src_data;
  logic [SEQ_W-1:0]  w_src_seq;
  logic [SAMPLE_W-1:0] w_sample;
  logic [AXI_W-1:0]  w_beat;
  logic              w_pkt_done;

  // The held word is the presented beat, so hold_valid doubles as m_tvalid.
  // A new word may enter on the very cycle its predecessor's last beat leaves.
  assign w_cur_last   = lane_is_last(r_mask, r_lane);
  assign w_fire       = r_hold_valid & bus.m_tready;
  assign w_accept_rdy = ~reset & in_start_stop & (~r_hold_valid | (w_fire & w_cur_last));
  assign w_accept     = w_accept_rdy & bus.s_tvalid;

  // Packet configuration is sampled only by the first word of a packet.
  assign w_new_pkt   = (r_idx == 13'd0);
  assign w_word_mask = w_new_pkt ? in_channel : r_mask;
  assign w_word_sel  = w_new_pkt ? packet_sel : r_sel;
  assign w_len_m1    = 13'(pkt_len(w_word_sel) - 14'd1);
  assign w_word_last = (r_idx == w_len_m1);

  assign w_sel_mask = w_accept ? w_word_mask : r_mask;

  gyro_lane_sel u_lane_sel (
    .i_start   (w_accept),
    .i_mask    (w_sel_mask),
    .i_lane    (r_lane),
    .o_lane    (w_next_lane),
    .o_is_last (w_next_is_last)
  );

  assign w_src_data = w_accept ? bus.s_tdata : r_hold_data;
  assign w_src_seq  = w_accept ? r_seq : r_hold_seq;

  // Sample for the lane about to be presented.
  always_comb begin
    w_sample = w_src_data[15:0];
    case (w_next_lane)
      LANE2:   w_sample = w_src_data[47:32];
      LANE1:   w_sample = w_src_data[31:16];
      default: w_sample = w_src_data[15:0];
    endcase
  end

  assign w_beat = {w_next_lane, 2'b00, 12'(w_src_seq), w_sample};

  // A packet completes on its tlast beat, or at the accept of its final word
  // when no lanes are enabled and nothing is emitted.
  assign w_pkt_done = (w_fire & r_tlast) |
                      (w_accept & w_word_last & (w_word_mask == 3'b000));

  // Word accept loads a fresh beat; otherwise a fired beat steps to the next
  // enabled lane or retires the word after its last lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_seq   <= '0;
      r_lane       <= LANE0;
      r_mask       <= 3'b000;
      r_sel        <= 3'b000;
      r_seq        <= '0;
      r_idx        <= 13'd0;
      r_word_last  <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_pkt_cnt    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_seq       <= r_seq + 1'b1;
        r_hold_data <= bus.s_tdata;
        r_hold_seq  <= r_seq;
        if (w_new_pkt) begin
          r_mask <= in_channel;
          r_sel  <= packet_sel;
        end
        r_idx        <= w_word_last ? 13'd0 : r_idx + 13'd1;
        r_word_last  <= w_word_last;
        r_hold_valid <= (w_word_mask != 3'b000);
        r_lane       <= w_next_lane;
        r_tdata      <= w_beat;
        r_tlast      <= w_word_last & w_next_is_last;
      end else if (w_fire) begin
        if (w_cur_last) begin
          r_hold_valid <= 1'b0;
          r_tlast      <= 1'b0;
        end else begin
          r_lane  <= w_next_lane;
          r_tdata <= w_beat;
          r_tlast <= r_word_last & w_next_is_last;
        end
      end
      if (w_pkt_done)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign bus.s_tready = w_accept_rdy;
  assign bus.m_tdata  = r_tdata;
  assign bus.m_tvalid = r_hold_valid;
  assign bus.m_tlast  = r_tlast;
  assign packet_count = r_pkt_cnt;
  assign busy         = r_hold_valid | (r_idx != 13'd0);

endmodule
